// File: rtl/dft_axi_pkg.sv
// Shared types and helpers for the DFT AXI4-Lite register front end.
package dft_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WSTB, BRSP, RWAIT, RRSP} state_t;
  typedef enum logic {SERVED_READ, SERVED_WRITE} served_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        err;
  } decode_t;

  // Caller zero-extends addr, so bits above the real address width never flag.
  function automatic decode_t decode_addr(input logic [63:0] addr, input int unsigned reg_aw);
    decode_t d;
    d.idx = 32'(addr >> 2) & ((32'd1 << reg_aw) - 32'd1);
    d.err = |(addr >> (reg_aw + 32'd2));
    return d;
  endfunction

endpackage

// File: rtl/dft_axi_hold.sv
// One-entry holding register for an AXI channel, with same-cycle bypass view.
module dft_axi_hold #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  output logic         avail,
  output logic [W-1:0] q
);

  logic         full;
  logic         full_d;
  logic         take;
  logic [W-1:0] data;

  assign take   = in_valid & in_ready;
  assign full_d = pop ? 1'b0 : (full | take);

  // Ready is registered so it stays low through reset and rises one clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_d;
      in_ready <= ~full_d;
      if (take) data <= in_data;
    end
  end

  assign avail = full | take;
  assign q     = full ? data : in_data;

endmodule

// File: rtl/dft_axi_regs.sv
// AXI4-Lite slave that turns AXI transactions into single-cycle register-bus strobes.
module dft_axi_regs
  import dft_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned REG_AW     = 8,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                  AXI_S_ACLK,
  input  logic                  AXI_S_ARESETn,
  input  logic                  AXI_S_AWVALID,
  output logic                  AXI_S_AWREADY,
  input  logic [ADDR_WIDTH-1:0] AXI_S_AWADDR,
  input  logic [2:0]            AXI_S_AWPROT,
  input  logic                  AXI_S_WVALID,
  output logic                  AXI_S_WREADY,
  input  logic [31:0]           AXI_S_WDATA,
  input  logic [3:0]            AXI_S_WSTRB,
  output logic                  AXI_S_BVALID,
  input  logic                  AXI_S_BREADY,
  output logic [1:0]            AXI_S_BRESP,
  input  logic                  AXI_S_ARVALID,
  output logic                  AXI_S_ARREADY,
  input  logic [ADDR_WIDTH-1:0] AXI_S_ARADDR,
  input  logic [2:0]            AXI_S_ARPROT,
  output logic                  AXI_S_RVALID,
  input  logic                  AXI_S_RREADY,
  output logic [31:0]           AXI_S_RDATA,
  output logic [1:0]            AXI_S_RRESP,
  output logic                  REG_WE,
  output logic [REG_AW-1:0]     REG_WADDR,
  output logic [31:0]           REG_WDATA,
  output logic [3:0]            REG_WSTRB,
  output logic                  REG_RE,
  output logic [REG_AW-1:0]     REG_RADDR,
  input  logic [31:0]           REG_RDATA,
  input  logic                  REG_RVALID
);

  localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);

  state_t                  state_q, state_d;
  served_t                 last_q, last_d;
  logic                    we_d, re_d, bvalid_d, rvalid_d, wr_err_q, wr_err_d;
  logic [1:0]              bresp_d, rresp_d;
  logic [31:0]             rdata_d, wdata_d;
  logic [3:0]              wstrb_d;
  logic [REG_AW-1:0]       waddr_d, raddr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    aw_avail, w_avail, ar_avail, wr_pop, rd_pop, take_wr;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [35:0]             w_q;
  decode_t                 wr_dec, rd_dec;
  logic                    unused;

  assign wr_pop = (state_q == WSTB);
  assign rd_pop = (state_q == RRSP) & AXI_S_RREADY;

  dft_axi_hold #(.W(ADDR_WIDTH)) u_aw_hold (
    .clk(AXI_S_ACLK), .rst_n(AXI_S_ARESETn), .in_valid(AXI_S_AWVALID), .in_ready(AXI_S_AWREADY),
    .in_data(AXI_S_AWADDR), .pop(wr_pop), .avail(aw_avail), .q(aw_addr)
  );

  dft_axi_hold #(.W(36)) u_w_hold (
    .clk(AXI_S_ACLK), .rst_n(AXI_S_ARESETn), .in_valid(AXI_S_WVALID), .in_ready(AXI_S_WREADY),
    .in_data({AXI_S_WSTRB, AXI_S_WDATA}), .pop(wr_pop), .avail(w_avail), .q(w_q)
  );

  dft_axi_hold #(.W(ADDR_WIDTH)) u_ar_hold (
    .clk(AXI_S_ACLK), .rst_n(AXI_S_ARESETn), .in_valid(AXI_S_ARVALID), .in_ready(AXI_S_ARREADY),
    .in_data(AXI_S_ARADDR), .pop(rd_pop), .avail(ar_avail), .q(ar_addr)
  );

  assign wr_dec  = decode_addr(64'(aw_addr), REG_AW);
  assign rd_dec  = decode_addr(64'(ar_addr), REG_AW);
  assign unused  = ^{AXI_S_AWPROT, AXI_S_ARPROT, wr_dec.idx[31:REG_AW], rd_dec.idx[31:REG_AW]};
  // Arbitration history only moves when both directions contend.
  assign take_wr = aw_avail & w_avail & (~ar_avail | (last_q == SERVED_READ));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    bvalid_d = AXI_S_BVALID;
    bresp_d  = AXI_S_BRESP;
    rvalid_d = AXI_S_RVALID;
    rresp_d  = AXI_S_RRESP;
    rdata_d  = AXI_S_RDATA;
    waddr_d  = REG_WADDR;
    wdata_d  = REG_WDATA;
    wstrb_d  = REG_WSTRB;
    raddr_d  = REG_RADDR;
    wr_err_d = wr_err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_wr) begin
          if (ar_avail) last_d = SERVED_WRITE;
          state_d  = WSTB;
          we_d     = ~wr_dec.err;
          wr_err_d = wr_dec.err;
          waddr_d  = wr_dec.idx[REG_AW-1:0];
          wdata_d  = w_q[31:0];
          wstrb_d  = w_q[35:32];
        end else if (ar_avail) begin
          if (aw_avail & w_avail) last_d = SERVED_READ;
          raddr_d = rd_dec.idx[REG_AW-1:0];
          cnt_d   = '0;
          if (rd_dec.err) begin
            state_d  = RRSP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
          end else begin
            state_d = RWAIT;
            re_d    = 1'b1;
          end
        end
      end
      WSTB: begin
        state_d  = BRSP;
        bvalid_d = 1'b1;
        bresp_d  = wr_err_q ? RESP_DECERR : RESP_OKAY;
      end
      BRSP: begin
        if (AXI_S_BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RWAIT: begin
        if (REG_RVALID) begin
          state_d  = RRSP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = REG_RDATA;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          state_d  = RRSP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = '0;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      RRSP: begin
        if (AXI_S_RREADY) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_S_ACLK or negedge AXI_S_ARESETn) begin
    if (!AXI_S_ARESETn) begin
      state_q      <= IDLE;
      last_q       <= SERVED_READ;
      REG_WE       <= 1'b0;
      REG_RE       <= 1'b0;
      AXI_S_BVALID <= 1'b0;
      AXI_S_BRESP  <= '0;
      AXI_S_RVALID <= 1'b0;
      AXI_S_RRESP  <= '0;
      AXI_S_RDATA  <= '0;
      REG_WADDR    <= '0;
      REG_WDATA    <= '0;
      REG_WSTRB    <= '0;
      REG_RADDR    <= '0;
      wr_err_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      REG_WE       <= we_d;
      REG_RE       <= re_d;
      AXI_S_BVALID <= bvalid_d;
      AXI_S_BRESP  <= bresp_d;
      AXI_S_RVALID <= rvalid_d;
      AXI_S_RRESP  <= rresp_d;
      AXI_S_RDATA  <= rdata_d;
      REG_WADDR    <= waddr_d;
      REG_WDATA    <= wdata_d;
      REG_WSTRB    <= wstrb_d;
      REG_RADDR    <= raddr_d;
      wr_err_q     <= wr_err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
